reg_op_sequencer: RTL and testbench
===================================

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 The block SHALL use exactly one clock, clk; rst SHALL be synchronous and active-high.
REQ-002 Parameter: RD_LAT, default 1, cycles from the rdr-asserted edge to valid rdata (range 1..4).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 instr_valid  in  1  an instruction is presented on op/rd/rs/rt.
REQ-006 instr_ready  out  1  block is idle and accepts an instruction this cycle.
REQ-007 op  in  3  ALU operation code.
REQ-008 rd, rs, rt  in  3 each  destination, source-A and source-B register addresses.
REQ-009 PA  out  3  register-bank address.
REQ-010 rdr  out  1  register-bank read strobe.
REQ-011 wrr  out  1  register-bank write strobe.
REQ-012 wPA  out  16  register-bank write data.
REQ-013 rdata  in  16  register-bank read data.
REQ-014 result  out  16  last computed result, held until the next EXEC.
REQ-015 done  out  1  one-cycle pulse, coincident with the write-back cycle.

Function
REQ-016 The FSM states SHALL be IDLE, RDA, WTA, RDB, WTB, EXEC, WR.
REQ-017 instr_ready SHALL be 1 only in IDLE; on a clk edge with instr_valid=1 and instr_ready=1, the block SHALL latch op/rd/rs/rt and move to RDA.
REQ-018 RDA: PA=rs, rdr=1 for exactly one cycle, then WTA.
REQ-019 WTA: remain RD_LAT cycles, rdr=0; capture rdata into operand A on the last WTA cycle; then RDB.
REQ-020 RDB/WTB: identical to RDA/WTA using rt, capturing operand B; then EXEC.
REQ-021 EXEC: one cycle; register result; then WR.
REQ-022 WR: PA=rd, wrr=1, wPA=result, done=1 for exactly one cycle; then IDLE.
REQ-023 Latency from accept edge to WR cycle: 2*(RD_LAT+1)+2 cycles (6 at RD_LAT=1); instr_ready SHALL return to 1 the cycle after WR.
REQ-024 Ops: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 ~A, 110 A<<1 (LSB 0), 111 A (MOV); all results truncated to 16 bits (modulo 2^16 wrap).
REQ-025 Operand B SHALL be read for every op, including 101/110/111, so latency is op-independent.
REQ-026 Outside RDA/RDB, PA SHALL be 0, except in WR, where PA=rd; outside WR, wrr=0 and wPA=0.
REQ-027 rdr and wrr SHALL never be 1 in the same cycle.
REQ-028 instr_valid while busy SHALL be ignored; the instruction is not queued.
REQ-029 rd equal to rs or rt SHALL be legal; the sources are read before the write, so the old value is used.

Reset
REQ-030 While rst=1 at a clk edge: state=IDLE; operands, result, PA, wPA=0; rdr, wrr, done=0; instr_ready=1 from the following cycle.
REQ-031 Reset in any non-IDLE state SHALL abort the instruction; no wrr pulse and no done pulse SHALL follow.
REQ-032 rst SHALL take priority over instr_valid on the same edge.

Configuration
REQ-033 Macro ALU_FLAGS_EN: when defined, outputs zf, cf, nf (1 bit each) SHALL exist, be updated in EXEC and be held otherwise; reset value is 0.
REQ-034 With ALU_FLAGS_EN, flags are: zf = (result==0); nf = result[15]; cf = carry-out for ADD, borrow for SUB (A<B), A[15] for SHL, and 0 for all other ops.
REQ-035 Without ALU_FLAGS_EN, zf/cf/nf SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Bank model R1=0x0404, R2=0x0407, RD_LAT=1; ADD rd=3 rs=1 rt=2 -> WR on the 6th cycle after accept: PA=3, wrr=1, wPA=0x080B, done=1.
REQ-037 R1=0xFFFF, R2=0x0001; ADD rd=1 rs=1 rt=1 is not used; instead ADD rd=4 rs=1 rt=2 -> wPA=0x0000; with ALU_FLAGS_EN: zf=1, cf=1, nf=0.
REQ-038 R1=0x0003, R2=0x0005; SUB rd=1 rs=1 rt=2 -> wPA=0xFFFE, written to R1; with flags: cf=1, nf=1.
REQ-039 Hold instr_valid=1 across two back-to-back instructions -> second accepted only on the cycle instr_ready returns; no overlap of rdr/wrr; two done pulses 7 cycles apart.
REQ-040 Assert rst in WTB of a MOV -> no wrr and no done; next cycle instr_ready=1, PA=0, result=0.
REQ-041 RD_LAT=3, SHL rd=5 rs=2 (R2=0x8001) -> WR at cycle 10 after accept, wPA=0x0002; with flags: cf=1.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// Register-bank ALU sequencer: reads two operands, executes one op, writes the result back.
// Optional ALU_FLAGS_EN adds zero/carry/negative flag outputs updated on every EXEC.
module reg_op_sequencer #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  op,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    output logic [2:0]  PA,
    output logic        rdr,
    output logic        wrr,
    output logic [15:0] wPA,
    input  logic [15:0] rdata,
    output logic [15:0] result,
    output logic        done
`ifdef ALU_FLAGS_EN
    ,
    output logic        zf,
    output logic        cf,
    output logic        nf
`endif
);

    typedef enum logic [2:0] {IDLE, RDA, WTA, RDB, WTB, EXEC, WR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  op_q, rd_q, rs_q, rt_q;
    logic [15:0] a_q, b_q;
    logic [15:0] alu_r;
    logic        last_wait;

    assign last_wait = (cnt_q == 3'(RD_LAT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            result  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && instr_valid) begin
                op_q <= op;
                rd_q <= rd;
                rs_q <= rs;
                rt_q <= rt;
            end
            // wait counter restarts on every entry into WTA/WTB
            if ((state_q == WTA || state_q == WTB) && !last_wait) cnt_q <= cnt_q + 3'd1;
            else cnt_q <= '0;
            if (state_q == WTA && last_wait) a_q <= rdata;
            if (state_q == WTB && last_wait) b_q <= rdata;
            if (state_q == EXEC) result <= alu_r;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        PA          = '0;
        rdr         = 1'b0;
        wrr         = 1'b0;
        wPA         = '0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = RDA;
            end
            RDA: begin
                PA      = rs_q;
                rdr     = 1'b1;
                state_d = WTA;
            end
            WTA:  if (last_wait) state_d = RDB;
            RDB: begin
                PA      = rt_q;
                rdr     = 1'b1;
                state_d = WTB;
            end
            WTB:  if (last_wait) state_d = EXEC;
            EXEC: state_d = WR;
            WR: begin
                PA      = rd_q;
                wrr     = 1'b1;
                wPA     = result;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_r = '0;
        case (op_q)
            3'b000: alu_r = a_q + b_q;
            3'b001: alu_r = a_q - b_q;
            3'b010: alu_r = a_q & b_q;
            3'b011: alu_r = a_q | b_q;
            3'b100: alu_r = a_q ^ b_q;
            3'b101: alu_r = ~a_q;
            3'b110: alu_r = {a_q[14:0], 1'b0};
            default: alu_r = a_q;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [16:0] add_w;
    logic        alu_c;

    assign add_w = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        alu_c = 1'b0;
        case (op_q)
            3'b000:  alu_c = add_w[16];
            3'b001:  alu_c = (a_q < b_q);
            3'b110:  alu_c = a_q[15];
            default: alu_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zf <= 1'b0;
            cf <= 1'b0;
            nf <= 1'b0;
        end else if (state_q == EXEC) begin
            zf <= (alu_r == 16'h0000);
            cf <= alu_c;
            nf <= alu_r[15];
        end
    end
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Scoreboard bench for reg_op_sequencer: RD_LAT=1 instance for the main flow, RD_LAT=3 for latency.
module tb_reg_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_tot = 0;

    logic        v1, rdy1, rdr1, wrr1, done1;
    logic [2:0]  op1, rd1, rs1, rt1, pa1;
    logic [15:0] wpa1, rdata1, res1;
    logic        v3, rdy3, rdr3, wrr3, done3;
    logic [2:0]  op3, rd3, rs3, rt3, pa3;
    logic [15:0] wpa3, rdata3, res3;
`ifdef ALU_FLAGS_EN
    logic        zf1, cf1, nf1, zf3, cf3, nf3;
`endif

    logic        ld_en;
    logic [2:0]  ld_a;
    logic [15:0] ld_d;
    logic [15:0] bank1 [8];
    logic [15:0] bank3 [8];
    logic [3:0]  rp1;
    logic [3:0]  rp3 [3];
    logic [15:0] ref_r [8];

    typedef struct {
        logic [2:0]  pa;
        logic [15:0] wpa;
        logic        z, c, n;
        int          acc;
    } exp_t;
    exp_t sb[$];
    int   done_cyc[$];

    localparam int LAT1 = 2 * (1 + 1) + 2 - 1;
    localparam int LAT3 = 2 * (3 + 1) + 2 - 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_op_sequencer #(.RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .instr_valid(v1), .instr_ready(rdy1),
        .op(op1), .rd(rd1), .rs(rs1), .rt(rt1), .PA(pa1), .rdr(rdr1), .wrr(wrr1),
        .wPA(wpa1), .rdata(rdata1), .result(res1), .done(done1)
`ifdef ALU_FLAGS_EN
        , .zf(zf1), .cf(cf1), .nf(nf1)
`endif
    );

    reg_op_sequencer #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .instr_valid(v3), .instr_ready(rdy3),
        .op(op3), .rd(rd3), .rs(rs3), .rt(rt3), .PA(pa3), .rdr(rdr3), .wrr(wrr3),
        .wPA(wpa3), .rdata(rdata3), .result(res3), .done(done3)
`ifdef ALU_FLAGS_EN
        , .zf(zf3), .cf(cf3), .nf(nf3)
`endif
    );

    // Bank models: read data is only valid exactly RD_LAT edges after the strobe.
    always @(posedge clk) begin
        if (ld_en) begin
            bank1[ld_a] <= ld_d;
            bank3[ld_a] <= ld_d;
        end
        if (wrr1) bank1[pa1] <= wpa1;
        if (wrr3) bank3[pa3] <= wpa3;
        rp1    <= {rdr1, pa1};
        rp3[0] <= {rdr3, pa3};
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign rdata1 = rp1[3] ? bank1[rp1[2:0]] : 16'hBAD0;
    assign rdata3 = rp3[2][3] ? bank3[rp3[2][2:0]] : 16'hBAD0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    function automatic logic [18:0] alu_m(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        c = 1'b0;
        s = {1'b0, a} + {1'b0, b};
        case (o)
            3'd0: begin r = s[15:0]; c = s[16]; end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[14:0], 1'b0}; c = a[15]; end
            default: r = a;
        endcase
        return {(r == 16'h0), c, r[15], r};
    endfunction

    // Monitor for the RD_LAT=1 instance
    always @(negedge clk) begin
        if (!rst) begin
            if (rdr1 || wrr1 || done1) chk("strobe_excl", {30'b0, rdr1 & wrr1, done1 ^ wrr1}, 0);
            if (wrr1) begin
                if (sb.size() == 0) chk("unexpected_wr", {29'b0, pa1}, 32'hFFFF);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_pa", pa1, e.pa);
                    chk("wr_data", wpa1, e.wpa);
                    chk("wr_latency", cyc - e.acc, LAT1);
`ifdef ALU_FLAGS_EN
                    chk("flags", {zf1, cf1, nf1}, {e.z, e.c, e.n});
`endif
                    done_cyc.push_back(cyc);
                end
            end else if (!rdr1) chk("idle_bus", {pa1, wpa1}, 0);
        end
    end

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_a = a; ld_d = d; ref_r[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s,
                         input logic [2:0] t, input bit keep, input bit push);
        int n = 0;
        logic [18:0] m;
        exp_t e;
        op1 = o; rd1 = d; rs1 = s; rt1 = t; v1 = 1'b1;
        while (!rdy1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("issue_timeout", n, 0);
        m = alu_m(o, ref_r[s], ref_r[t]);
        @(posedge clk);
        #1;
        if (push) begin
            e.pa = d; e.wpa = m[15:0]; e.z = m[18]; e.c = m[17]; e.n = m[16]; e.acc = cyc;
            sb.push_back(e);
            ref_r[d] = m[15:0];
        end
        @(negedge clk);
        if (!keep) v1 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int acc;
        rst = 1'b1; v1 = 1'b0; v3 = 1'b0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
        op1 = '0; rd1 = '0; rs1 = '0; rt1 = '0; op3 = '0; rd3 = '0; rs3 = '0; rt3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {rdy1, rdy3}, 2'b11);
        chk("rst_bus", {pa1, rdr1, wrr1, wpa1, done1}, 0);
        chk("rst_result", res1, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) load(3'(i), 16'(i * 16'h1111));

        load(3'd1, 16'h0404); load(3'd2, 16'h0407);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1);
        drain();
        chk("add_bank", bank1[3], 16'h080B);

        load(3'd1, 16'hFFFF); load(3'd2, 16'h0001);
        issue(3'd0, 3'd4, 3'd1, 3'd2, 1'b0, 1'b1);
        drain();
        chk("add_wrap", bank1[4], 16'h0000);

        load(3'd1, 16'h0003); load(3'd2, 16'h0005);
        issue(3'd1, 3'd1, 3'd1, 3'd2, 1'b0, 1'b1);
        drain();
        chk("sub_rd_eq_rs", bank1[1], 16'hFFFE);

        for (int k = 0; k < 16; k++) begin
            logic [2:0] s, t;
            s = 3'($urandom_range(0, 7));
            t = 3'($urandom_range(0, 7));
            load(s, 16'($urandom));
            if (k == 6) load(s, 16'h8001);
            issue(3'(k % 8), 3'($urandom_range(0, 7)), s, t, 1'b0, 1'b1);
            drain();
        end

        done_cyc.delete();
        issue(3'd0, 3'd5, 3'd1, 3'd2, 1'b1, 1'b1);
        issue(3'd4, 3'd6, 3'd5, 3'd1, 1'b0, 1'b1);
        drain();
        chk("b2b_pulses", done_cyc.size(), 2);
        if (done_cyc.size() == 2) chk("b2b_spacing", done_cyc[1] - done_cyc[0], 7);

        issue(3'd7, 3'd7, 3'd3, 3'd4, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", rdy1, 1'b1);
        chk("abort_pa", pa1, 0);
        chk("abort_result", res1, 0);
        chk("abort_strobes", {wrr1, done1}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_wr", sb.size(), 0);

        load(3'd2, 16'h8001);
        op3 = 3'd6; rd3 = 3'd5; rs3 = 3'd2; rt3 = 3'd0; v3 = 1'b1;
        chk("l3_ready", rdy3, 1'b1);
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        v3 = 1'b0;
        n = 0;
        while (!wrr3 && n < 40) begin @(negedge clk); n++; end
        chk("l3_wr_seen", wrr3, 1'b1);
        chk("l3_latency", cyc - acc, LAT3);
        chk("l3_pa", pa3, 3'd5);
        chk("l3_data", wpa3, 16'h0002);
        chk("l3_done", done3, 1'b1);
`ifdef ALU_FLAGS_EN
        chk("l3_cf", cf3, 1'b1);
`endif
        @(negedge clk);
        chk("l3_ready_back", rdy3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
